// File: rtl/ifetch_q_pkg.sv
// Shared CPU constants: default address/instruction widths and the reset fetch vector.
package ifetch_q_pkg;

  localparam int          CPU_AWIDTH    = 24;
  localparam int          CPU_IWIDTH    = 24;
  localparam logic [23:0] CPU_RESET_VEC = 24'h000000;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue storage: DEPTH-entry circular buffer with occupancy count and flush.
module fetch_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rstb,
  input  logic                   i_flush,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_data,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [PW:0]      count_r;

  assign o_data  = mem_r[rd_ptr_r];
  assign o_count = count_r;
  assign o_empty = (count_r == {(PW+1){1'b0}});

  // Entry storage; cleared on reset so the head reads zero until first write
  always_ff @(posedge i_clk or negedge i_rstb) begin
    if (!i_rstb) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (i_push && !i_flush) begin
      mem_r[wr_ptr_r] <= i_data;
    end
  end

  // Pointers and occupancy; flush overrides any same-cycle push or pop
  always_ff @(posedge i_clk or negedge i_rstb) begin
    if (!i_rstb) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {(PW+1){1'b0}};
    end else if (i_flush) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {(PW+1){1'b0}};
    end else begin
      if (i_push) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (i_pop)  rd_ptr_r <= rd_ptr_r + PW'(1);
      case ({i_push, i_pop})
        2'b10:   count_r <= count_r + (PW+1)'(1);
        2'b01:   count_r <= count_r - (PW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/ifetch_q.sv
// Instruction fetch with prefetch queue; one outstanding memory request, epoch-tagged for flushes.
// Optional macro IFETCH_BYPASS_EN forwards a return straight to decode when the queue is empty.
module ifetch_q
  import ifetch_q_pkg::*;
#(
  parameter int                AWIDTH    = CPU_AWIDTH,
  parameter int                IWIDTH    = CPU_IWIDTH,
  parameter int                DEPTH     = 4,
  parameter logic [AWIDTH-1:0] RESET_VEC = AWIDTH'(CPU_RESET_VEC)
) (
  input  logic              i_clk,
  input  logic              i_rstb,
  input  logic              i_clk_en,
  output logic [AWIDTH-1:0] o_iaddr,
  output logic              o_ireq,
  input  logic              i_iready,
  input  logic [IWIDTH-1:0] i_instr,
  output logic [IWIDTH-1:0] o_instr,
  output logic [AWIDTH-1:0] o_instr_pc,
  output logic              o_valid,
  input  logic              i_ready,
  input  logic              i_redirect,
  input  logic [AWIDTH-1:0] i_redirect_pc
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = AWIDTH + IWIDTH;

  logic [AWIDTH-1:0] pc_r;
  logic [AWIDTH-1:0] inflight_pc_r;
  logic              inflight_r;
  logic              inflight_epoch_r;
  logic              epoch_r;

  logic              redirect_s;
  logic              accept_s;
  logic              ret_ok_s;
  logic              bypass_s;
  logic              pop_s;
  logic              fifo_push_s;
  logic              fifo_pop_s;
  logic              fifo_empty_s;
  logic [CW-1:0]     count_s;
  logic [CW-1:0]     credit_s;
  logic [EW-1:0]     head_s;

  assign redirect_s = i_clk_en & i_redirect;
  assign credit_s   = count_s + CW'(inflight_r);
  assign o_ireq     = i_rstb & i_clk_en & ~i_redirect & (credit_s < CW'(DEPTH));
  assign accept_s   = o_ireq & i_iready;
  assign o_iaddr    = pc_r;

  // A return is kept only if it belongs to the current epoch and no flush is happening now
  assign ret_ok_s = i_clk_en & ~i_redirect & inflight_r & (inflight_epoch_r == epoch_r);

`ifdef IFETCH_BYPASS_EN
  assign bypass_s = ret_ok_s & fifo_empty_s;
`else
  assign bypass_s = 1'b0;
`endif

  assign o_valid                = ~fifo_empty_s | bypass_s;
  assign {o_instr_pc, o_instr}  = bypass_s ? {inflight_pc_r, i_instr} : head_s;
  assign pop_s                  = o_valid & i_ready & i_clk_en & ~i_redirect;
  assign fifo_pop_s             = pop_s & ~fifo_empty_s;
  assign fifo_push_s            = ret_ok_s & ~(bypass_s & pop_s);

  // Fetch PC, outstanding-request tracking and flush epoch
  always_ff @(posedge i_clk or negedge i_rstb) begin
    if (!i_rstb) begin
      pc_r             <= RESET_VEC;
      inflight_r       <= 1'b0;
      inflight_pc_r    <= {AWIDTH{1'b0}};
      inflight_epoch_r <= 1'b0;
      epoch_r          <= 1'b0;
    end else if (i_clk_en) begin
      if (redirect_s) begin
        pc_r    <= i_redirect_pc;
        epoch_r <= ~epoch_r;
      end else if (accept_s) begin
        pc_r <= pc_r + AWIDTH'(1);
      end
      inflight_r <= accept_s;
      if (accept_s) begin
        inflight_pc_r    <= pc_r;
        inflight_epoch_r <= epoch_r;
      end
    end
  end

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rstb  (i_rstb),
    .i_flush (redirect_s),
    .i_push  (fifo_push_s),
    .i_data  ({inflight_pc_r, i_instr}),
    .i_pop   (fifo_pop_s),
    .o_data  (head_s),
    .o_count (count_s),
    .o_empty (fifo_empty_s)
  );

endmodule

// File: tb/tb_ifetch_q.sv
// Directed bench for ifetch_q: memory model returns the address as data; scoreboard follows the stream.
module tb_ifetch_q;

`ifdef IFETCH_BYPASS_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 3;
`endif
  localparam logic [23:0] RV = 24'hFFFFFE;

  logic        clk;
  logic        rstb;
  logic        clk_en;
  logic [23:0] iaddr;
  logic        ireq;
  logic        iready;
  logic [23:0] mem_instr;
  logic [23:0] instr;
  logic [23:0] instr_pc;
  logic        valid;
  logic        ready;
  logic        redirect;
  logic [23:0] redirect_pc;

  int          checks = 0;
  int          errors = 0;
  int          delivered = 0;
  int          acc_cnt = 0;
  int          d0;
  logic [23:0] exp_pc;
  logic [23:0] exp_iaddr;
  logic        prev_ok;

  ifetch_q #(
    .AWIDTH    (24),
    .IWIDTH    (24),
    .DEPTH     (4),
    .RESET_VEC (RV)
  ) dut (
    .i_clk         (clk),
    .i_rstb        (rstb),
    .i_clk_en      (clk_en),
    .o_iaddr       (iaddr),
    .o_ireq        (ireq),
    .i_iready      (iready),
    .i_instr       (mem_instr),
    .o_instr       (instr),
    .o_instr_pc    (instr_pc),
    .o_valid       (valid),
    .i_ready       (ready),
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory: data = address, one cycle after an accepted request, frozen when clock-gated
  always @(posedge clk) begin
    if (rstb && clk_en && ireq && iready) mem_instr <= iaddr;
  end

  function automatic logic [23:0] add24(input logic [23:0] b, input int off);
    return b + 24'(off);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at the negedge: scoreboard the delivered stream, check address progression, advance
  task automatic end_cycle();
    if (prev_ok) check_eq("iaddr_seq", iaddr, exp_iaddr);
    if (clk_en && valid && ready && !redirect) begin
      check_eq("stream_pc", instr_pc, exp_pc);
      check_eq("stream_data", instr, exp_pc);
      exp_pc = exp_pc + 24'd1;
      delivered++;
    end
    if (clk_en && ireq && iready) acc_cnt++;
    if (clk_en && redirect)            exp_iaddr = redirect_pc;
    else if (clk_en && ireq && iready) exp_iaddr = iaddr + 24'd1;
    else                               exp_iaddr = iaddr;
    prev_ok = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Cycle k after reset release or redirect: address base+k-1, head base+k-LAT from cycle LAT
  task automatic seq_run(input string tag, input logic [23:0] base, input int n);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      check_eq({tag, "_iaddr"}, iaddr, add24(base, k - 1));
      check_eq({tag, "_valid"}, valid, (k >= LAT));
      if (k >= LAT) check_eq({tag, "_pc"}, instr_pc, add24(base, k - LAT));
      end_cycle();
    end
  endtask

  initial begin
    rstb = 1'b0; clk_en = 1'b1; iready = 1'b1; ready = 1'b1;
    redirect = 1'b0; redirect_pc = 24'h0; mem_instr = 24'h0;
    exp_pc = RV; exp_iaddr = RV; prev_ok = 1'b0;
    #12;
    check_eq("rst_valid", valid, 0);
    check_eq("rst_ireq", ireq, 0);
    check_eq("rst_iaddr", iaddr, RV);
    check_eq("rst_instr", instr, 0);
    check_eq("rst_instr_pc", instr_pc, 0);
    @(posedge clk);
    #1;
    rstb = 1'b1;

    // Boot stream crosses the address wrap FFFFFE, FFFFFF, 000000
    seq_run("boot", RV, 10);

    // Redirect while head 6 pops and the return for address 7 arrives
    redirect = 1'b1; redirect_pc = 24'h100;
    @(negedge clk);
    check_eq("redir_ireq", ireq, 0);
    end_cycle();
    redirect = 1'b0; exp_pc = 24'h100;
    seq_run("redir", 24'h100, 8);

    // Redirect then stall decode: exactly DEPTH requests accepted, none lost on release
    redirect = 1'b1; redirect_pc = 24'h200;
    @(negedge clk);
    end_cycle();
    redirect = 1'b0; exp_pc = 24'h200; ready = 1'b0; acc_cnt = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) check_eq("flush_empty", valid, 0);
      if (k == 10) begin
        check_eq("full_ireq", ireq, 0);
        check_eq("full_valid", valid, 1);
        check_eq("full_head", instr_pc, 24'h200);
      end
      end_cycle();
    end
    check_eq("full_accepts", acc_cnt, 4);
    ready = 1'b1; d0 = delivered;
    repeat (12) begin
      @(negedge clk);
      end_cycle();
    end
    check_eq("drain_count", delivered - d0, 12);

    // Clock-enable toggling with random memory back-pressure
    d0 = delivered;
    for (int k = 0; k < 60; k++) begin
      clk_en = (k % 2 == 0);
      iready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (!clk_en) check_eq("gated_ireq", ireq, 0);
      end_cycle();
    end
    clk_en = 1'b1; iready = 1'b1;
    repeat (10) begin
      @(negedge clk);
      end_cycle();
    end
    check_eq("gated_progress", (delivered - d0) >= 8, 1);

    // Reset pulse mid-stream
    rstb = 1'b0;
    #1;
    check_eq("mid_rst_valid", valid, 0);
    check_eq("mid_rst_iaddr", iaddr, RV);
    check_eq("mid_rst_ireq", ireq, 0);
    prev_ok = 1'b0; exp_pc = RV;
    @(posedge clk);
    #1;
    rstb = 1'b1;
    seq_run("restart", RV, 6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
